// File: rtl/red_pitaya_lpf_pkg.sv
// Shared widths and arithmetic helpers for the low-pass cascade.
// Helpers work on a fixed wide signed type so any stage width up to MAX_BITS-1 can reuse them.
package red_pitaya_lpf_pkg;

  localparam int unsigned DEF_NSTAGES         = 2;
  localparam int unsigned DEF_ALPHABITS       = 25;
  localparam int unsigned DEF_HIGHESTALPHABIT = 18;
  localparam int unsigned DEF_LPFBITS         = 14;
  localparam int unsigned ACCBITS             = DEF_LPFBITS + DEF_ALPHABITS;

  localparam int unsigned MAX_BITS = 64;

  typedef logic signed [MAX_BITS-1:0] wide_t;

  localparam logic [MAX_BITS:0] WIDE_ONE = {{MAX_BITS{1'b0}}, 1'b1};

  // Add two width-bit signed values (sign-extended into wide_t) and clamp to the width-bit range.
  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int unsigned width);
    logic signed [MAX_BITS:0] sum;
    logic signed [MAX_BITS:0] max_v;
    logic signed [MAX_BITS:0] min_v;
    sum   = {a[MAX_BITS-1], a} + {b[MAX_BITS-1], b};
    max_v = (WIDE_ONE << (width - 1)) - WIDE_ONE;
    min_v = ~max_v;
    if (sum > max_v) begin
      return max_v[MAX_BITS-1:0];
    end else if (sum < min_v) begin
      return min_v[MAX_BITS-1:0];
    end
    return sum[MAX_BITS-1:0];
  endfunction

  // Integer part of a fixed-point accumulator, sign-extended (floor towards minus infinity).
  function automatic wide_t acc_hi_slice(input wide_t acc, input int unsigned frac_bits);
    return acc >>> frac_bits;
  endfunction

endpackage

// File: rtl/red_pitaya_lpf_stage.sv
// One first-order IIR low-pass stage: acc tracks x with gain alpha, y is the integer part of acc.
// The product is registered before accumulation so the multiplier has a full cycle.
module red_pitaya_lpf_stage
  import red_pitaya_lpf_pkg::*;
#(
  parameter int unsigned ALPHABITS       = DEF_ALPHABITS,
  parameter int unsigned HIGHESTALPHABIT = DEF_HIGHESTALPHABIT,
  parameter int unsigned LPFBITS         = DEF_LPFBITS
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic signed [HIGHESTALPHABIT-1:0] alpha,
  input  logic                              bypass,
  input  logic                              hold,
  input  logic signed [LPFBITS-1:0]         x,
  output logic signed [LPFBITS-1:0]         y
);

  localparam int unsigned AccW  = LPFBITS + ALPHABITS;
  localparam int unsigned ProdW = LPFBITS + 1 + HIGHESTALPHABIT;

  logic signed [AccW-1:0]    r_acc;
  logic signed [AccW-1:0]    r_delta;
  logic signed [LPFBITS-1:0] r_y;

  wide_t                     w_acc_wide;
  wide_t                     w_hi_wide;
  wide_t                     w_prod_wide;
  wide_t                     w_sum_wide;
  logic signed [LPFBITS-1:0] w_acc_hi;
  logic signed [LPFBITS:0]   w_diff;
  logic signed [ProdW-1:0]   w_prod;
  logic signed [AccW-1:0]    w_delta_d;
  logic signed [AccW-1:0]    w_acc_d;
  logic                      w_unused;

  always_comb begin
    w_acc_wide  = wide_t'(r_acc);
    w_hi_wide   = acc_hi_slice(w_acc_wide, ALPHABITS);
    w_acc_hi    = w_hi_wide[LPFBITS-1:0];
    // One extra bit keeps x - acc_hi exact across the full signed range.
    w_diff      = {x[LPFBITS-1], x} - {w_acc_hi[LPFBITS-1], w_acc_hi};
    w_prod      = w_diff * alpha;
    w_prod_wide = wide_t'(w_prod);
    w_delta_d   = w_prod_wide[AccW-1:0];
    w_sum_wide  = sat_add(w_acc_wide, wide_t'(r_delta), AccW);
    w_acc_d     = w_sum_wide[AccW-1:0];
  end

  assign w_unused = ^{w_hi_wide[MAX_BITS-1:LPFBITS], w_prod_wide[MAX_BITS-1:AccW],
                      w_sum_wide[MAX_BITS-1:AccW]};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_acc   <= '0;
      r_delta <= '0;
      r_y     <= '0;
    end else if (bypass) begin
      // Preload acc with the input so re-enabling starts without a transient.
      r_acc   <= {x, {ALPHABITS{1'b0}}};
      r_delta <= '0;
      r_y     <= x;
    end else if (hold) begin
      r_delta <= '0;
      r_y     <= w_acc_hi;
    end else begin
      r_acc   <= w_acc_d;
      r_delta <= w_delta_d;
      r_y     <= w_acc_hi;
    end
  end

  assign y = r_y;

endmodule

// File: rtl/red_pitaya_lpf_cascade.sv
// Cascade of NSTAGES first-order low-pass stages; stage k filters the output of stage k-1.
// Bypassed stages add one register of latency, active stages three.
module red_pitaya_lpf_cascade
  import red_pitaya_lpf_pkg::*;
#(
  parameter int unsigned NSTAGES         = DEF_NSTAGES,
  parameter int unsigned ALPHABITS       = DEF_ALPHABITS,
  parameter int unsigned HIGHESTALPHABIT = DEF_HIGHESTALPHABIT,
  parameter int unsigned LPFBITS         = DEF_LPFBITS
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [NSTAGES*HIGHESTALPHABIT-1:0]   alpha_i,
  input  logic [NSTAGES-1:0]                   bypass_i,
  input  logic                                 hold_i,
  input  logic signed [LPFBITS-1:0]            signal_i,
  output logic signed [LPFBITS-1:0]            signal_o
);

  logic signed [LPFBITS-1:0] w_chain [NSTAGES+1];

  assign w_chain[0] = signal_i;

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    red_pitaya_lpf_stage #(
      .ALPHABITS      (ALPHABITS),
      .HIGHESTALPHABIT(HIGHESTALPHABIT),
      .LPFBITS        (LPFBITS)
    ) u_stage (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .alpha  (alpha_i[k*HIGHESTALPHABIT +: HIGHESTALPHABIT]),
      .bypass (bypass_i[k]),
      .hold   (hold_i),
      .x      (w_chain[k]),
      .y      (w_chain[k+1])
    );
  end

  assign signal_o = w_chain[NSTAGES];

endmodule
